// File: rtl/regfile_pkg.sv
// Shared types and default parameters for the multi-port register file.
`timescale 1ns/1ps
package regfile_pkg;

   // Clear-sweep controller states
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_e;

   localparam int unsigned DEF_DATA_W  = 16;
   localparam int unsigned DEF_ADDR_W  = 3;
   localparam int unsigned DEF_NUM_RD  = 2;
   localparam bit          DEF_ZERO_R0 = 1'b1;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address decode, write bypass and busy flag.
// Write/set enables arrive already qualified (reset, sweep and r0 filtering done by the top).
`timescale 1ns/1ps
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter bit          ZERO_R0 = DEF_ZERO_R0,
   parameter int unsigned DEPTH   = 2 ** ADDR_W
) (
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_ra,
   input  logic [DATA_W-1:0] i_mem [DEPTH],
   input  logic [DEPTH-1:0]  i_pend,
   input  logic              i_we0,
   input  logic [ADDR_W-1:0] i_wa0,
   input  logic [DATA_W-1:0] i_wd0,
   input  logic              i_we1,
   input  logic [ADDR_W-1:0] i_wa1,
   input  logic [DATA_W-1:0] i_wd1,
   input  logic              i_sb_set,
   input  logic [ADDR_W-1:0] i_sb_addr,
   output logic [DATA_W-1:0] o_rd,
   output logic              o_busy
);

   logic w_hit0;
   logic w_hit1;
   logic w_sb_hit;

   assign w_hit0   = i_we0 && (i_wa0 == i_ra);
   assign w_hit1   = i_we1 && (i_wa1 == i_ra);
   assign w_sb_hit = i_sb_set && (i_sb_addr == i_ra);

   // Read mux with bypass (port 1 over port 0); a write only hides busy if no new producer
   always_comb begin
      o_rd   = '0;
      o_busy = 1'b0;
      if (!rst) begin
         if (w_hit1) begin
            o_rd = i_wd1;
         end else if (w_hit0) begin
            o_rd = i_wd0;
         end else begin
            o_rd = i_mem[i_ra];
         end
         o_busy = i_pend[i_ra] & ~((w_hit0 | w_hit1) & ~w_sb_hit);
         if (ZERO_R0 && (i_ra == '0)) begin
            o_rd   = '0;
            o_busy = 1'b0;
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, NUM_RD bypassed read ports,
// a per-entry pending scoreboard and a sequential clear sweep.
`timescale 1ns/1ps
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned NUM_RD  = DEF_NUM_RD,
   parameter bit          ZERO_R0 = DEF_ZERO_R0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_we0,
   input  logic                     i_we1,
   input  logic [ADDR_W-1:0]        i_wa0,
   input  logic [ADDR_W-1:0]        i_wa1,
   input  logic [DATA_W-1:0]        i_wd0,
   input  logic [DATA_W-1:0]        i_wd1,
   input  logic [NUM_RD*ADDR_W-1:0] i_ra,
   output logic [NUM_RD*DATA_W-1:0] o_rd,
   output logic [NUM_RD-1:0]        o_busy,
   input  logic                     i_sb_set,
   input  logic [ADDR_W-1:0]        i_sb_addr,
   input  logic                     i_clr_req,
   output logic                     o_clr_busy
);

   localparam int unsigned       DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_pend;
   state_e            r_state;
   state_e            w_state_d;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] w_idx_d;

   logic w_active;
   logic w_we0;
   logic w_we1;
   logic w_sb_set;

   // Requests only take effect in IDLE outside reset; r0 writes/sets vanish when hardwired
   assign w_active = !rst && (r_state == IDLE);
   assign w_we0    = i_we0 && w_active && !(ZERO_R0 && (i_wa0 == '0));
   assign w_we1    = i_we1 && w_active && !(ZERO_R0 && (i_wa1 == '0));
   assign w_sb_set = i_sb_set && w_active && !(ZERO_R0 && (i_sb_addr == '0));

   assign o_clr_busy = (r_state == SWEEP);

   // Sweep controller state and index register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_d;
         r_idx   <= w_idx_d;
      end
   end

   // Sweep next-state: run DEPTH cycles, index wraps back to 0 on exit
   always_comb begin
      w_state_d = r_state;
      w_idx_d   = r_idx;
      case (r_state)
         IDLE: begin
            if (i_clr_req) begin
               w_state_d = SWEEP;
               w_idx_d   = '0;
            end
         end
         SWEEP: begin
            w_idx_d = r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
               w_state_d = IDLE;
            end
         end
         default: begin
            w_state_d = IDLE;
            w_idx_d   = '0;
         end
      endcase
   end

   // Storage and scoreboard; sb_set is applied last so a new producer wins over a write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
         r_pend <= '0;
      end else if (r_state == SWEEP) begin
         r_mem[r_idx]  <= '0;
         r_pend[r_idx] <= 1'b0;
      end else begin
         if (w_we0) begin
            r_mem[i_wa0]  <= i_wd0;
            r_pend[i_wa0] <= 1'b0;
         end
         if (w_we1) begin
            r_mem[i_wa1]  <= i_wd1;
            r_pend[i_wa1] <= 1'b0;
         end
         if (w_sb_set) begin
            r_pend[i_sb_addr] <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_rd
      regfile_read_port #(
         .DATA_W  (DATA_W),
         .ADDR_W  (ADDR_W),
         .ZERO_R0 (ZERO_R0),
         .DEPTH   (DEPTH)
      ) u_read_port (
         .rst       (rst),
         .i_ra      (i_ra[g*ADDR_W +: ADDR_W]),
         .i_mem     (r_mem),
         .i_pend    (r_pend),
         .i_we0     (w_we0),
         .i_wa0     (i_wa0),
         .i_wd0     (i_wd0),
         .i_we1     (w_we1),
         .i_wa1     (i_wa1),
         .i_wd1     (i_wd1),
         .i_sb_set  (w_sb_set),
         .i_sb_addr (i_sb_addr),
         .o_rd      (o_rd[g*DATA_W +: DATA_W]),
         .o_busy    (o_busy[g])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (defaults: 16-bit, 8 entries, 2 read ports).
// Inputs change at the falling edge; outputs are sampled 1ns later.
`timescale 1ns/1ps
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_we0, i_we1;
   logic [2:0]  i_wa0, i_wa1;
   logic [15:0] i_wd0, i_wd1;
   logic [5:0]  i_ra;
   logic [31:0] o_rd;
   logic [1:0]  o_busy;
   logic        i_sb_set;
   logic [2:0]  i_sb_addr;
   logic        i_clr_req;
   logic        o_clr_busy;

   logic [15:0] rd0, rd1;
   assign rd0 = o_rd[15:0];
   assign rd1 = o_rd[31:16];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   regfile_mp #(
      .DATA_W  (16),
      .ADDR_W  (3),
      .NUM_RD  (2),
      .ZERO_R0 (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_we0      (i_we0),
      .i_we1      (i_we1),
      .i_wa0      (i_wa0),
      .i_wa1      (i_wa1),
      .i_wd0      (i_wd0),
      .i_wd1      (i_wd1),
      .i_ra       (i_ra),
      .o_rd       (o_rd),
      .o_busy     (o_busy),
      .i_sb_set   (i_sb_set),
      .i_sb_addr  (i_sb_addr),
      .i_clr_req  (i_clr_req),
      .o_clr_busy (o_clr_busy)
   );

   task automatic idle_inputs();
      i_we0 = 1'b0; i_we1 = 1'b0; i_sb_set = 1'b0; i_clr_req = 1'b0;
   endtask

   task automatic fill_regs();
      for (int a = 1; a < 8; a++) begin
         @(negedge clk);
         idle_inputs();
         i_we0 = 1'b1; i_wa0 = 3'(a); i_wd0 = 16'h1000 + 16'(a);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      i_wa0 = 3'd3; i_wa1 = 3'd0; i_wd0 = 16'h0; i_wd1 = 16'h0; i_sb_addr = 3'd0;
      i_ra = {3'd3, 3'd3};
      @(negedge clk);
      i_we0 = 1'b1; i_wd0 = 16'h7777; i_sb_set = 1'b1; i_sb_addr = 3'd3; i_clr_req = 1'b1;
      #1;
      n_tests++; if (o_rd !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h expected %h", o_rd, 32'h0); end
      n_tests++; if (o_busy !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %b expected %b", o_busy, 2'b00); end
      @(negedge clk);
      #1;
      n_tests++; if (o_clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_clr_busy: got %b expected %b", o_clr_busy, 1'b0); end
      idle_inputs();
      rst = 1'b0;
      #1;
      n_tests++; if (rd0 !== 16'h0) begin n_fail++; $display("FAIL reset_write_ignored: got %h expected %h", rd0, 16'h0); end
      n_tests++; if (o_busy !== 2'b00) begin n_fail++; $display("FAIL reset_sb_ignored: got %b expected %b", o_busy, 2'b00); end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      idle_inputs();
      i_we0 = 1'b1; i_wa0 = 3'd3; i_wd0 = 16'h1234; i_ra = {3'd0, 3'd3};
      #1;
      n_tests++; if (rd0 !== 16'h1234) begin n_fail++; $display("FAIL bypass_p0: got %h expected %h", rd0, 16'h1234); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_tests++; if (rd0 !== 16'h1234) begin n_fail++; $display("FAIL read_after_write: got %h expected %h", rd0, 16'h1234); end
      @(negedge clk);
      i_we0 = 1'b1; i_wd0 = 16'h5555; i_ra = {3'd3, 3'd3};
      #1;
      n_tests++; if (rd0 !== 16'h5555) begin n_fail++; $display("FAIL bypass_new_rd0: got %h expected %h", rd0, 16'h5555); end
      n_tests++; if (rd1 !== 16'h5555) begin n_fail++; $display("FAIL bypass_new_rd1: got %h expected %h", rd1, 16'h5555); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_tests++; if (rd1 !== 16'h5555) begin n_fail++; $display("FAIL stored_5555: got %h expected %h", rd1, 16'h5555); end
   endtask

   task automatic test_dual_write();
      @(negedge clk);
      idle_inputs();
      i_we0 = 1'b1; i_wa0 = 3'd5; i_wd0 = 16'hAAAA;
      i_we1 = 1'b1; i_wa1 = 3'd5; i_wd1 = 16'hBBBB;
      i_ra = {3'd3, 3'd5};
      #1;
      n_tests++; if (rd0 !== 16'hBBBB) begin n_fail++; $display("FAIL same_addr_bypass: got %h expected %h", rd0, 16'hBBBB); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_tests++; if (rd0 !== 16'hBBBB) begin n_fail++; $display("FAIL same_addr_stored: got %h expected %h", rd0, 16'hBBBB); end
      @(negedge clk);
      i_we0 = 1'b1; i_wa0 = 3'd6; i_wd0 = 16'h1111;
      i_we1 = 1'b1; i_wa1 = 3'd1; i_wd1 = 16'h2222;
      i_ra = {3'd1, 3'd6};
      #1;
      n_tests++; if (o_rd !== 32'h2222_1111) begin n_fail++; $display("FAIL split_bypass: got %h expected %h", o_rd, 32'h2222_1111); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_tests++; if (o_rd !== 32'h2222_1111) begin n_fail++; $display("FAIL split_stored: got %h expected %h", o_rd, 32'h2222_1111); end
   endtask

   task automatic test_zero_r0();
      @(negedge clk);
      idle_inputs();
      i_we1 = 1'b1; i_wa1 = 3'd0; i_wd1 = 16'hFFFF; i_ra = {3'd5, 3'd0};
      #1;
      n_tests++; if (rd0 !== 16'h0) begin n_fail++; $display("FAIL r0_no_bypass: got %h expected %h", rd0, 16'h0); end
      @(negedge clk);
      idle_inputs();
      i_sb_set = 1'b1; i_sb_addr = 3'd0;
      #1;
      n_tests++; if (rd0 !== 16'h0) begin n_fail++; $display("FAIL r0_stored: got %h expected %h", rd0, 16'h0); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_tests++; if (o_busy[0] !== 1'b0) begin n_fail++; $display("FAIL r0_never_busy: got %b expected %b", o_busy[0], 1'b0); end
      n_tests++; if (rd1 !== 16'hBBBB) begin n_fail++; $display("FAIL r0_other_intact: got %h expected %h", rd1, 16'hBBBB); end
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      idle_inputs();
      i_sb_set = 1'b1; i_sb_addr = 3'd2; i_ra = {3'd2, 3'd2};
      #1;
      n_tests++; if (o_busy !== 2'b00) begin n_fail++; $display("FAIL sb_set_cycle: got %b expected %b", o_busy, 2'b00); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_tests++; if (o_busy !== 2'b11) begin n_fail++; $display("FAIL sb_pending: got %b expected %b", o_busy, 2'b11); end
      i_we0 = 1'b1; i_wa0 = 3'd2; i_wd0 = 16'h0222;
      #1;
      n_tests++; if (o_busy !== 2'b00) begin n_fail++; $display("FAIL sb_write_cycle: got %b expected %b", o_busy, 2'b00); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_tests++; if (o_busy !== 2'b00) begin n_fail++; $display("FAIL sb_after_write: got %b expected %b", o_busy, 2'b00); end
      i_we1 = 1'b1; i_wa1 = 3'd2; i_wd1 = 16'h0333; i_sb_set = 1'b1; i_sb_addr = 3'd2;
      @(negedge clk);
      idle_inputs();
      #1;
      n_tests++; if (o_busy !== 2'b11) begin n_fail++; $display("FAIL sb_new_producer: got %b expected %b", o_busy, 2'b11); end
      n_tests++; if (rd0 !== 16'h0333) begin n_fail++; $display("FAIL sb_write_data: got %h expected %h", rd0, 16'h0333); end
      // Pending r2, then write it together with a set on r4: port reading r2 unblocks
      i_we0 = 1'b1; i_wa0 = 3'd2; i_wd0 = 16'h0444; i_sb_set = 1'b1; i_sb_addr = 3'd4;
      i_ra = {3'd4, 3'd2};
      #1;
      n_tests++; if (o_busy !== 2'b00) begin n_fail++; $display("FAIL sb_other_addr: got %b expected %b", o_busy, 2'b00); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_tests++; if (o_busy !== 2'b10) begin n_fail++; $display("FAIL sb_r4_pending: got %b expected %b", o_busy, 2'b10); end
   endtask

   task automatic test_sweep();
      int cnt;
      fill_regs();
      i_sb_set = 1'b1; i_sb_addr = 3'd4;
      @(negedge clk);
      idle_inputs();
      i_clr_req = 1'b1; i_ra = {3'd4, 3'd7};
      #1;
      n_tests++; if (o_busy[1] !== 1'b1) begin n_fail++; $display("FAIL pre_sweep_pending: got %b expected %b", o_busy[1], 1'b1); end
      n_tests++; if (rd0 !== 16'h1007) begin n_fail++; $display("FAIL pre_sweep_r7: got %h expected %h", rd0, 16'h1007); end
      @(negedge clk);
      // Hammer writes, sets and another clear request throughout the sweep
      i_we0 = 1'b1; i_wa0 = 3'd7; i_wd0 = 16'hDEAD;
      i_we1 = 1'b1; i_wa1 = 3'd3; i_wd1 = 16'hBEEF;
      i_sb_set = 1'b1; i_sb_addr = 3'd5;
      #1;
      n_tests++; if (rd0 !== 16'h1007) begin n_fail++; $display("FAIL sweep_no_bypass: got %h expected %h", rd0, 16'h1007); end
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (!o_clr_busy) break;
         cnt++;
         @(negedge clk);
         i_clr_req = 1'b0;
         #1;
      end
      idle_inputs();
      n_tests++; if (cnt !== 8) begin n_fail++; $display("FAIL sweep_length: got %0d expected %0d", cnt, 8); end
      for (int a = 0; a < 8; a++) begin
         i_ra = {3'(a), 3'(a)};
         #1;
         n_tests++; if (o_rd !== 32'h0) begin n_fail++; $display("FAIL swept_r%0d: got %h expected %h", a, o_rd, 32'h0); end
         n_tests++; if (o_busy !== 2'b00) begin n_fail++; $display("FAIL swept_busy_r%0d: got %b expected %b", a, o_busy, 2'b00); end
      end
      @(negedge clk);
      #1;
      n_tests++; if (o_clr_busy !== 1'b0) begin n_fail++; $display("FAIL sweep_stays_idle: got %b expected %b", o_clr_busy, 1'b0); end
   endtask

   task automatic test_reset_mid_sweep();
      int cnt;
      fill_regs();
      i_clr_req = 1'b1; i_ra = {3'd1, 3'd7};
      @(negedge clk);
      i_clr_req = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_tests++; if (o_clr_busy !== 1'b1) begin n_fail++; $display("FAIL mid_sweep_busy: got %b expected %b", o_clr_busy, 1'b1); end
      n_tests++; if (rd0 !== 16'h1007) begin n_fail++; $display("FAIL mid_sweep_r7: got %h expected %h", rd0, 16'h1007); end
      rst = 1'b1;
      #1;
      n_tests++; if (o_clr_busy !== 1'b0) begin n_fail++; $display("FAIL abort_clr_busy: got %b expected %b", o_clr_busy, 1'b0); end
      n_tests++; if (o_rd !== 32'h0) begin n_fail++; $display("FAIL abort_rd: got %h expected %h", o_rd, 32'h0); end
      @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 8; a++) begin
         i_ra = {3'(a), 3'(a)};
         #1;
         n_tests++; if (o_rd !== 32'h0) begin n_fail++; $display("FAIL abort_zero_r%0d: got %h expected %h", a, o_rd, 32'h0); end
      end
      @(negedge clk);
      #1;
      n_tests++; if (o_clr_busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b expected %b", o_clr_busy, 1'b0); end
      i_clr_req = 1'b1;
      @(negedge clk);
      i_clr_req = 1'b0;
      #1;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (!o_clr_busy) break;
         cnt++;
         @(negedge clk);
         #1;
      end
      n_tests++; if (cnt !== 8) begin n_fail++; $display("FAIL resweep_length: got %0d expected %0d", cnt, 8); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_dual_write();
      test_zero_r0();
      test_scoreboard();
      test_sweep();
      test_reset_mid_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion expected finish before 100000ns");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 Parameter ZERO_R0, default 1, when 1 entry 0 reads as zero, ignores writes, is never busy.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 we0, we1  input  1 each  write enables, ports 0 and 1.
REQ-008 wa0, wa1  input  ADDR_W each  write addresses.
REQ-009 wd0, wd1  input  DATA_W each  write data.
REQ-010 ra  input  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-011 rd  output  NUM_RD*DATA_W  packed read data, same packing.
REQ-012 busy  output  NUM_RD  scoreboard pending flag for each read address.
REQ-013 sb_set, sb_addr  input  1 / ADDR_W  mark sb_addr pending (producer issued).
REQ-014 clr_req  input  1  single-cycle pulse requesting a sequential clear sweep.
REQ-015 clr_busy  output  1  high while the clear sweep runs.

Function
REQ-016 Writes SHALL commit on the rising edge when enabled; both ports to the same address -> port 1 data wins.
REQ-017 Reads SHALL be combinational, zero latency, with bypass: a same-cycle enabled write to ra_i returns that write data (port 1 over port 0), otherwise stored data.
REQ-018 ZERO_R0=1: reads of address 0 SHALL return 0; writes to address 0 SHALL be dropped, never bypassed.
REQ-019 Scoreboard: one pending bit per entry; sb_set sets it at the edge; an enabled write to an entry clears it at the edge.
REQ-020 sb_set and a write to the same address in the same cycle -> bit SHALL end set (new producer wins).
REQ-021 busy[i] SHALL equal pending[ra_i] AND NOT (a same-cycle enabled write to ra_i without a same-cycle sb_set to ra_i).
REQ-022 FSM states IDLE, SWEEP; IDLE + clr_req -> SWEEP with index 0.
REQ-023 In SWEEP, each cycle SHALL zero data and pending of entry[index], then increment index; after index DEPTH-1 -> IDLE.
REQ-024 clr_busy SHALL be high for exactly DEPTH cycles, from the cycle after clr_req through the cycle clearing entry DEPTH-1.
REQ-025 During SWEEP, writes, sb_set and clr_req SHALL be ignored; bypass disabled; reads return stored contents (cleared entries read 0).
REQ-026 Index counter SHALL be ADDR_W bits and wrap to 0 on SWEEP exit.

Reset
REQ-027 rst SHALL immediately zero all entries and pending bits, force IDLE, index 0, clr_busy 0.
REQ-028 While rst is high, rd SHALL be all zeros, busy all zeros, and bypass disabled.
REQ-029 rst asserted mid-SWEEP SHALL abort the sweep; after release the block is in IDLE with all entries zero.

Structure
REQ-030 Package regfile_pkg SHALL hold the FSM state type (IDLE, SWEEP) and default parameter constants.
REQ-031 Sub-module regfile_read_port (address decode, bypass mux, busy logic) SHALL be instantiated NUM_RD times via generate.

Verification
REQ-032 Reset, write r3=0x1234 via port 0, next cycle ra0=3 -> rd0=0x1234; same-cycle read while writing 0x5555 -> rd0=0x5555.
REQ-033 we0,we1 both to r5 with 0xAAAA / 0xBBBB -> r5=0xBBBB; same-cycle read of r5 returns 0xBBBB.
REQ-034 ZERO_R0=1, write r0=0xFFFF -> rd=0x0000; sb_set r0 -> busy stays 0.
REQ-035 sb_set r2 -> busy=1; write r2 -> busy=0 in write cycle, 0 after; sb_set+write r2 same cycle -> busy=1 after.
REQ-036 Fill r1..r7 nonzero, pulse clr_req -> clr_busy high 8 cycles, writes during sweep dropped, all reads 0 afterwards.
REQ-037 rst asserted at sweep cycle 3 -> clr_busy drops immediately, all entries 0, new clr_req after release runs full 8-cycle sweep.
